// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: credit-limited linear prefetch into a small FIFO for VGA scan-out, writer served in spare slots.
// Pixel latency 1 clock; writer held until wr_ack. Define FB_UNDERFLOW_CNT_EN to add the saturating underflow_cnt output.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int PIX_TOTAL  = 307200,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk27,
  input  logic              rst27_n,
  input  logic              frame_start,
  input  logic              vid_request,
  output logic [9:0]        pix_r,
  output logic [9:0]        pix_g,
  output logic [9:0]        pix_b,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  output logic              sram_we,
  output logic              sram_rd,
  input  logic [15:0]       sram_rdata,
  output logic              underflow
`ifdef FB_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LVL_W = CNT_W + 3;
  localparam int RA_W  = ADDR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  state_t            r_state, w_next;
  logic [15:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [RD_LAT-1:0] r_tag;
  logic [RA_W-1:0]   r_rd_addr;
  logic [9:0]        r_pix_r, r_pix_g, r_pix_b;
  logic              r_underflow;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [15:0]       r_sram_wdata;

  logic [LVL_W-1:0]  w_level;
  logic              w_rd_elig, w_urgent, w_empty, w_push, w_pop, w_uf_pop;
  logic [15:0]       w_head;

  // Level counts the slot being issued now plus every read still in the return pipe.
  always_comb begin
    w_level = LVL_W'(r_count) + LVL_W'(r_state == ST_READ);
    for (int i = 0; i < RD_LAT; i++) begin
      w_level = w_level + LVL_W'(r_tag[i]);
    end
  end

  assign w_rd_elig = (w_level < LVL_W'(FIFO_DEPTH)) && (r_rd_addr < RA_W'(PIX_TOTAL));
  assign w_urgent  = w_rd_elig && (w_level < LVL_W'(FIFO_DEPTH / 2));
  assign w_empty   = (r_count == '0);
  assign w_push    = r_tag[RD_LAT-1] && !frame_start;
  assign w_pop     = vid_request && !frame_start && !w_empty;
  assign w_uf_pop  = vid_request && !frame_start && w_empty;
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk27 or negedge rst27_n) begin
    if (!rst27_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    if (w_urgent)                          w_next = ST_READ;
    else if (wr_req && r_state != ST_WRITE) w_next = ST_WRITE;
    else if (w_rd_elig)                    w_next = ST_READ;
    if (frame_start && w_next == ST_READ)  w_next = ST_IDLE;
  end

  always_comb begin
    sram_rd = 1'b0;
    sram_we = 1'b0;
    case (r_state)
      ST_READ:  sram_rd = 1'b1;
      ST_WRITE: sram_we = 1'b1;
      default:  ;
    endcase
  end

  assign wr_ack     = sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;

  always_ff @(posedge clk27 or negedge rst27_n) begin
    if (!rst27_n) begin
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_rd_addr    <= '0;
    end else begin
      if (w_next == ST_READ) begin
        r_sram_addr <= r_rd_addr[ADDR_W-1:0];
      end else if (w_next == ST_WRITE) begin
        r_sram_addr  <= wr_addr;
        r_sram_wdata <= wr_data;
      end
      if (frame_start)            r_rd_addr <= '0;
      else if (w_next == ST_READ) r_rd_addr <= r_rd_addr + RA_W'(1);
    end
  end

  // Clearing the tags on frame_start drops any returns still on their way.
  always_ff @(posedge clk27 or negedge rst27_n) begin
    if (!rst27_n) begin
      r_tag <= '0;
    end else if (frame_start) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= sram_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk27) begin
    if (w_push) r_mem[r_wptr] <= sram_rdata;
  end

  always_ff @(posedge clk27 or negedge rst27_n) begin
    if (!rst27_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (frame_start) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk27 or negedge rst27_n) begin
    if (!rst27_n) begin
      r_pix_r     <= '0;
      r_pix_g     <= '0;
      r_pix_b     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (vid_request) begin
        if (w_pop) begin
          r_pix_r <= {w_head[15:11], w_head[15:11]};
          r_pix_g <= {w_head[10:5],  w_head[10:7]};
          r_pix_b <= {w_head[4:0],   w_head[4:0]};
        end else begin
          r_pix_r <= '0;
          r_pix_g <= '0;
          r_pix_b <= '0;
        end
      end
      if (frame_start)   r_underflow <= 1'b0;
      else if (w_uf_pop) r_underflow <= 1'b1;
    end
  end

  assign pix_r     = r_pix_r;
  assign pix_g     = r_pix_g;
  assign pix_b     = r_pix_b;
  assign underflow = r_underflow;

`ifdef FB_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_cnt;

  always_ff @(posedge clk27 or negedge rst27_n) begin
    if (!rst27_n)                                r_uf_cnt <= '0;
    else if (w_uf_pop && r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
  end

  assign underflow_cnt = r_uf_cnt;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: SRAM model plus a queue-based frame-buffer reference checked every cycle, with directed literal checks.
module tb_vga_fb_arbiter;
  localparam int AW     = 10;
  localparam int TB_PIX = 700;
  localparam int LAT    = 2;
  localparam int DEPTH  = 8;

  logic          clk27 = 1'b0;
  logic          rst27_n;
  logic          frame_start, vid_request, wr_req;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [9:0]    pix_r, pix_g, pix_b;
  logic          wr_ack, sram_we, sram_rd, underflow;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata;
  logic [15:0]   sram_rdata = 16'h0;
`ifdef FB_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  vga_fb_arbiter #(.ADDR_W(AW), .PIX_TOTAL(TB_PIX), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk27(clk27), .rst27_n(rst27_n), .frame_start(frame_start), .vid_request(vid_request),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .sram_rd(sram_rd), .sram_rdata(sram_rdata), .underflow(underflow)
`ifdef FB_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk27 = ~clk27;

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [29:0] expand(input logic [15:0] d);
    return {d[15:11], d[15:11], d[10:5], d[10:7], d[4:0], d[4:0]};
  endfunction

  // SRAM: the bench owns the array and returns read data LAT cycles after sram_rd.
  logic [15:0] mem [1024];
  logic        ret_vld [8];
  logic [15:0] ret_dat [8];
  int          cyc = 0;

  always @(posedge clk27) begin
    cyc = cyc + 1;
    #1;
    if (ret_vld[cyc % 8]) begin
      sram_rdata = ret_dat[cyc % 8];
      ret_vld[cyc % 8] = 1'b0;
    end else begin
      sram_rdata = 16'($urandom);
    end
  end

  // Reference: a FIFO of pixel words, a list of outstanding reads, and the arbitration priority list.
  typedef struct { int due; logic [15:0] dat; } ret_t;
  logic [15:0] fifo_q [$];
  ret_t        infl_q [$];
  ret_t        r;
  int          m_rd_addr = 0;
  int          rd_since_fs = 0;
  int          lvl;
  logic        exp_rd = 0, exp_we = 0, exp_uf = 0;
  logic        elig, urg, n_rd, n_we, ret_now;
  logic [29:0] exp_pix = '0;
  logic [AW-1:0] exp_waddr = '0;
  logic [15:0] exp_wdata = '0;
  logic [15:0] m_ucnt = '0;

  always @(negedge clk27) begin
    if (!rst27_n) begin
      cmp("reset_outputs", {pix_r, pix_g, pix_b, underflow, wr_ack, sram_we, sram_rd, sram_addr, sram_wdata}, 64'h0);
      fifo_q.delete();
      infl_q.delete();
      m_rd_addr = 0;
      exp_rd = 0; exp_we = 0; exp_uf = 0; exp_pix = '0; m_ucnt = '0;
    end else begin
      cmp("pix", {pix_r, pix_g, pix_b}, exp_pix);
      cmp("underflow", underflow, exp_uf);
      cmp("slot_rd_we_ack", {sram_rd, sram_we, wr_ack}, {exp_rd, exp_we, exp_we});
      if (exp_rd) cmp("read_addr", sram_addr, m_rd_addr);
      if (exp_we) cmp("write_addr_data", {sram_addr, sram_wdata}, {exp_waddr, exp_wdata});
`ifdef FB_UNDERFLOW_CNT_EN
      cmp("underflow_cnt", underflow_cnt, m_ucnt);
`endif
      if (sram_we) mem[sram_addr] = sram_wdata;
      if (sram_rd) begin
        ret_vld[(cyc + LAT) % 8] = 1'b1;
        ret_dat[(cyc + LAT) % 8] = mem[sram_addr];
        rd_since_fs++;
      end
      if (exp_rd) begin
        infl_q.push_back('{due: cyc + LAT, dat: mem[m_rd_addr]});
        m_rd_addr++;
      end
      lvl     = fifo_q.size() + infl_q.size();
      ret_now = (infl_q.size() > 0) && (infl_q[0].due == cyc);
      elig    = (lvl < DEPTH) && (m_rd_addr < TB_PIX);
      urg     = elig && (lvl < DEPTH / 2);
      n_rd = 0; n_we = 0;
      if (urg)                   n_rd = 1;
      else if (wr_req && !exp_we) n_we = 1;
      else if (elig)             n_rd = 1;
      if (frame_start) n_rd = 0;
      if (vid_request) begin
        if (frame_start) exp_pix = '0;
        else if (fifo_q.size() == 0) begin
          exp_pix = '0;
          exp_uf  = 1;
          if (m_ucnt != 16'hFFFF) m_ucnt++;
        end else exp_pix = expand(fifo_q.pop_front());
      end
      if (ret_now) begin
        r = infl_q.pop_front();
        if (!frame_start) fifo_q.push_back(r.dat);
      end
      if (frame_start) begin
        fifo_q.delete();
        infl_q.delete();
        m_rd_addr = 0;
        exp_uf = 0;
        rd_since_fs = 0;
      end
      exp_rd = n_rd;
      exp_we = n_we;
      if (n_we) begin
        exp_waddr = wr_addr;
        exp_wdata = wr_data;
      end
    end
  end

  task automatic step();
    @(posedge clk27);
    #2;
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (19) step();
  endtask

  logic got, ack;
  int   acks;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst27_n = 1'b1; frame_start = 0; vid_request = 0; wr_req = 0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) + 16'h1000;
    for (int i = 0; i < 8; i++) ret_vld[i] = 1'b0;
    #1 rst27_n = 1'b0;
    repeat (3) step();
    rst27_n = 1'b1;
    repeat (5) step();

    // Pixels requested one cycle after frame_start find the FIFO empty.
    frame_start = 1'b1; step(); frame_start = 1'b0;
    vid_request = 1'b1; repeat (3) step(); vid_request = 1'b0;
    @(negedge clk27);
    cmp("early_pop_underflow", underflow, 1'b1);
    cmp("early_pop_pix", {pix_r, pix_g, pix_b}, 30'h0);
`ifdef FB_UNDERFLOW_CNT_EN
    cmp("ucnt_three", underflow_cnt, 16'd3);
`endif
    step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    @(negedge clk27);
    cmp("underflow_cleared", underflow, 1'b0);
`ifdef FB_UNDERFLOW_CNT_EN
    cmp("ucnt_survives_fs", underflow_cnt, 16'd3);
`endif

    // One active line of 640 pixels, then idle until the FIFO is topped up.
    step();
    new_frame();
    vid_request = 1'b1; repeat (640) step(); vid_request = 1'b0;
    repeat (20) step();
    @(negedge clk27);
    cmp("line_no_underflow", underflow, 1'b0);
    cmp("line_reads", rd_since_fs, 648);
    cmp("pix639_r", pix_r, 10'h042);
    cmp("pix639_g", pix_g, 10'h134);
    cmp("pix639_b", pix_b, 10'h3FF);

    // Write while the FIFO is full; the pixel shows up red on the next frame.
    step();
    wr_addr = 10'd5; wr_data = 16'hF800; wr_req = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk27);
      if (wr_ack) got = 1;
      step();
    end
    wr_req = 1'b0;
    cmp("write_acked", got, 1'b1);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk27);
      if (wr_ack) acks++;
      step();
    end
    cmp("ack_single_pulse", acks, 0);
    new_frame();
    vid_request = 1'b1; repeat (6) step(); vid_request = 1'b0;
    @(negedge clk27);
    cmp("pix5_red", {pix_r, pix_g, pix_b}, {10'h3FF, 10'h000, 10'h000});

    // Restart mid-line with reads in flight: first pixel afterwards is address 0.
    step();
    new_frame();
    vid_request = 1'b1; repeat (10) step();
    vid_request = 1'b0; frame_start = 1'b1; step(); frame_start = 1'b0;
    repeat (20) step();
    vid_request = 1'b1; step(); vid_request = 1'b0;
    @(negedge clk27);
    cmp("restart_pix0", {pix_r, pix_g, pix_b}, {10'h042, 10'h000, 10'h000});

    // Reading past the end of the frame stops prefetch and drains into underflow.
    step();
    new_frame();
    vid_request = 1'b1; repeat (720) step(); vid_request = 1'b0;
    repeat (10) step();
    @(negedge clk27);
    cmp("frame_end_reads", rd_since_fs, TB_PIX);
    cmp("frame_end_underflow", underflow, 1'b1);
`ifdef FB_UNDERFLOW_CNT_EN
    cmp("ucnt_frame_end", underflow_cnt, 16'd23);
`endif
    step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    @(negedge clk27);
    cmp("frame_end_cleared", underflow, 1'b0);

    // Random traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk27);
      ack = wr_ack;
      step();
      if (i == 1500) rst27_n = 1'b0;
      if (i == 1503) rst27_n = 1'b1;
      frame_start = ($urandom_range(0, 1199) == 0);
      vid_request = ($urandom_range(0, 9) < 7);
      if (wr_req && ack) wr_req = 1'b0;
      else if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req  = 1'b1;
        wr_addr = AW'($urandom_range(0, 1023));
        wr_data = 16'($urandom);
      end
    end
    wr_req = 1'b0; vid_request = 1'b0; frame_start = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
